// File: rtl/mp_add_seq_if.sv
// Bundle of the mp_add_seq input stream, adder hookup and output stream.
// MP_ADD_OVF_EN adds the out_ovf signal alongside the output stream.
interface mp_add_seq_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  // input word stream
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_cin;
  logic          in_last;

  // external ripple-carry adder
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic          add_cin;
  logic [N-1:0]  add_sum;
  logic          add_cout;

  // registered output stream
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_last;
  logic          out_cout;
  logic [CW-1:0] out_words;
`ifdef MP_ADD_OVF_EN
  logic          out_ovf;
`endif

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_last,
    output in_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output out_valid, out_sum, out_last, out_cout, out_words,
    input  out_ready
`ifdef MP_ADD_OVF_EN
    , output out_ovf
`endif
  );

  // Producer / adder / consumer side.
  modport master (
    output in_valid, in_a, in_b, in_cin, in_last,
    input  in_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  out_valid, out_sum, out_last, out_cout, out_words,
    output out_ready
`ifdef MP_ADD_OVF_EN
    , input out_ovf
`endif
  );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: streams word pairs through an external N-bit
// adder, chaining the carry. Optional signed overflow output under MP_ADD_OVF_EN.
module mp_add_seq #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        rst,
  mp_add_seq_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CHAIN = 1'b1;

  logic [0:0]    state_q;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  logic          out_valid_q;
  logic [N-1:0]  out_sum_q;
  logic          out_last_q;
  logic          out_cout_q;
  logic [CW-1:0] out_words_q;

  logic          accept;
  logic          add_cin_c;

  // Registered output stage without skid buffer: new word only when the
  // current one leaves (or there is none).
  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.add_a   = bus.in_a;
  assign bus.add_b   = bus.in_b;
  assign bus.add_cin = add_cin_c;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    add_cin_c = bus.in_cin;
    if (state_q == CHAIN) add_cin_c = carry_q;
  end

  // Word count sticks at all-ones rather than wrapping on very long operands.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      carry_q <= bus.add_cout;
      if (bus.in_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= CHAIN;
        cnt_q   <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_words_q <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= bus.add_sum;
      out_last_q  <= bus.in_last;
      out_cout_q  <= bus.in_last & bus.add_cout;
      out_words_q <= bus.in_last ? cnt_inc : '0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_words = out_words_q;

`ifdef MP_ADD_OVF_EN
  logic ovf_word;
  logic out_ovf_q;

  // Signed overflow is decided by the most-significant word only.
  assign ovf_word = (bus.in_a[N-1] == bus.in_b[N-1]) &
                    (bus.add_sum[N-1] != bus.in_a[N-1]);

  always_ff @(posedge clk) begin
    if (rst)         out_ovf_q <= 1'b0;
    else if (accept) out_ovf_q <= bus.in_last & ovf_word;
  end

  assign bus.out_ovf = out_ovf_q;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: wide-integer transaction model plus
// directed cases; MP_ADD_OVF_EN enables the overflow checks.
module tb_mp_add_seq;
  localparam int N  = 8;
  localparam int CW = 8;

  typedef struct {
    logic [N-1:0]  sum;
    logic          last;
    logic          cout;
    logic [CW-1:0] words;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mp_add_seq_if #(.N(N), .CW(CW)) bus ();
  mp_add_seq #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-in for the team's ripple-carry adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                       + {{N{1'b0}}, bus.add_cin};

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t drv_exp;
  logic drv_add_cin = 1'b0;
  logic obs_add_cin = 1'b0;
  logic cmp_en      = 1'b0;
  logic rdy_rand    = 1'b0;
  logic rdy_force   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Model of the output register: a queue of at most one pending word.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      automatic logic model_ready = (q.size() == 0) || bus.out_ready;
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && model_ready) q.push_back(drv_exp);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("out_valid", bus.out_valid, q.size() != 0);
      check("in_ready", bus.in_ready, (q.size() == 0) || bus.out_ready);
      if (q.size() != 0) begin
        check("out_sum", bus.out_sum, q[0].sum);
        check("out_last", bus.out_last, q[0].last);
        check("out_cout", bus.out_cout, q[0].cout);
        check("out_words", bus.out_words, q[0].words);
`ifdef MP_ADD_OVF_EN
        check("out_ovf", bus.out_ovf, q[0].ovf);
`endif
      end
      if (bus.in_valid) begin
        check("add_a", bus.add_a, bus.in_a);
        check("add_b", bus.add_b, bus.in_b);
        check("add_cin", bus.add_cin, drv_add_cin);
      end
    end
  end

  task automatic send_word(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                           input logic last, input exp_t e, input logic acin);
    int  budget = 0;
    bit  got    = 0;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_last = last;
    drv_exp = e; drv_add_cin = acin;
    bus.in_valid = 1'b1;
    while (!got && budget < 1000) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        obs_add_cin = bus.add_cin;
      end
      budget++;
    end
    if (!got) check("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Expected words come from the whole-transaction sum A + B + cin.
  task automatic send_txn(input int len, input logic [63:0] aw, input logic [63:0] bw,
                          input logic cin, input int stop_at, input bit gaps);
    logic [71:0] mask, am, bm, tot, lowm, part;
    exp_t e;
    logic acin;
    mask = (72'd1 << (8 * len)) - 72'd1;
    am = {8'd0, aw} & mask;
    bm = {8'd0, bw} & mask;
    tot = am + bm + {71'd0, cin};
    for (int i = 0; i < len && i < stop_at; i++) begin
      lowm = (72'd1 << (8 * i)) - 72'd1;
      part = (am & lowm) + (bm & lowm) + {71'd0, cin};
      acin = (i == 0) ? cin : part[8 * i];
      e.sum   = tot[8 * i +: 8];
      e.last  = (i == len - 1);
      e.cout  = e.last ? tot[8 * len] : 1'b0;
      e.words = e.last ? CW'(len) : '0;
      e.ovf   = e.last ? ((am[8 * len - 1] == bm[8 * len - 1]) &&
                          (tot[8 * len - 1] != am[8 * len - 1])) : 1'b0;
      send_word(am[8 * i +: 8], bm[8 * i +: 8], cin, e.last, e, acin);
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    exp_t e;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_cin = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    drv_exp = '{sum: '0, last: 1'b0, cout: 1'b0, words: '0, ovf: 1'b0};
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);

    // Reset state and IDLE carry-in path.
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_cout", bus.out_cout, 0);
    check("rst_out_words", bus.out_words, 0);
`ifdef MP_ADD_OVF_EN
    check("rst_out_ovf", bus.out_ovf, 0);
`endif
    bus.in_cin = 1'b1; #1;
    check("rst_add_cin1", bus.add_cin, 1);
    bus.in_cin = 1'b0; #1;
    check("rst_add_cin0", bus.add_cin, 0);
    cmp_en = 1'b1;

    // Single word with carry-out, then hold under backpressure.
    rdy_force = 1'b0;
    @(posedge clk); #2;
    send_txn(1, 64'hFF, 64'h01, 1'b0, 1, 0);
    check("t1_sum", bus.out_sum, 8'h00);
    check("t1_cout", bus.out_cout, 1);
    check("t1_last", bus.out_last, 1);
    check("t1_words", bus.out_words, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_sum", bus.out_sum, 8'h00);
    end

    // Release: the pending word drains as the first word of the next one enters.
    rdy_force = 1'b1;
    send_txn(2, 64'h01FF, 64'h0001, 1'b0, 2, 0);
    check("t2_sum", bus.out_sum, 8'h02);
    check("t2_cout", bus.out_cout, 0);
    check("t2_words", bus.out_words, 2);
    check("t2_chain_cin", obs_add_cin, 1);

    // Reset in the middle of a transaction.
    send_txn(2, 64'hFFFF, 64'h0001, 1'b0, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", bus.out_valid, 0);
    send_txn(1, 64'h10, 64'h20, 1'b0, 1, 0);
    check("t3_sum", bus.out_sum, 8'h30);
    check("t3_cout", bus.out_cout, 0);
    check("t3_words", bus.out_words, 1);
    check("t3_first_cin", obs_add_cin, 0);

`ifdef MP_ADD_OVF_EN
    send_txn(1, 64'h7F, 64'h01, 1'b0, 1, 0);
    check("ovf_pos", bus.out_ovf, 1);
    send_txn(1, 64'h80, 64'h7F, 1'b0, 1, 0);
    check("ovf_none", bus.out_ovf, 0);
    check("ovf_none_sum", bus.out_sum, 8'hFF);
`endif

    // Word counter saturation on a 300-word all-zero transaction.
    for (int i = 0; i < 300; i++) begin
      e.sum = '0; e.last = (i == 299); e.cout = 1'b0; e.ovf = 1'b0;
      e.words = e.last ? CW'(255) : '0;
      send_word('0, '0, 1'b0, e.last, e, 1'b0);
    end
    check("sat_words", bus.out_words, 255);

    // Randomised transactions with random backpressure and input gaps.
    rdy_rand = 1'b1;
    for (int t = 0; t < 150; t++) begin
      automatic int          len = $urandom_range(1, 8);
      automatic logic [63:0] aw  = {$urandom, $urandom};
      automatic logic [63:0] bw  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        aw = '1;
        bw = 64'd1;
      end
      send_txn(len, aw, bw, 1'($urandom_range(0, 1)), len, 1);
    end

    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("final_drained", bus.out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
